// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between an ALU requester (master) and alu_op_sequencer (slave).
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 carry;
    logic                 negative;
    logic                 zero;
    logic                 err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, negative, zero, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, negative, zero, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/retire stage around an ADD/SUB/MUL datapath; op 11 is MAC when ALU_SEQ_ACC_EN is defined, else illegal.
// Latency: ADD/SUB/illegal 1 cycle, MUL/MAC MUL_LAT cycles from request accept to out_valid.
// Backpressure: one op in flight; in_ready only while IDLE, result held in DONE until out_ready.
module alu_op_sequencer #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus,
    output logic              busy
);
    localparam int RW = 2 * WIDTH;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    localparam logic [3:0] LONG_CNT = 4'(MUL_LAT - 1);

    generate
        if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
            $error("alu_op_sequencer: MUL_LAT must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [1:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [3:0]        cnt_q;

    logic              accept;
    logic              capture;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              busy_c;

    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  mag;
    logic              a_lt_b;
    logic [RW-1:0]     prod;

    logic [RW-1:0]     res_d;
    logic              carry_d;
    logic              neg_d;
    logic              err_d;

    logic [RW-1:0]     res_q;
    logic              carry_q;
    logic              neg_q;
    logic              zero_q;
    logic              err_q;

`ifdef ALU_SEQ_ACC_EN
    logic [RW-1:0]     acc_q;
    logic [RW:0]       mac_sum;
`endif

    // Multi-cycle ops occupy EXEC for MUL_LAT cycles; everything else for one.
    function automatic logic is_long_op(input logic [1:0] o);
`ifdef ALU_SEQ_ACC_EN
        return (o == OP_MUL) || (o == OP_MAC);
`else
        return (o == OP_MUL);
`endif
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)     state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == 4'd0)    state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)    state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                accept     = bus.in_valid;
            end
            ST_EXEC: begin
                capture = (cnt_q == 4'd0);
            end
            ST_DONE: begin
                out_valid_c = 1'b1;
            end
            default: begin
                busy_c = 1'b1;
            end
        endcase
    end

    // Operands are frozen at accept so the multiplier sees a stable input for the whole multicycle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= 2'b00;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= 4'd0;
        end else if (accept) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            cnt_q <= is_long_op(bus.op) ? LONG_CNT : 4'd0;
        end else if (state_q == ST_EXEC && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // ---------------- datapath ----------------
    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        a_lt_b = (a_q < b_q);
        mag    = a_lt_b ? (b_q - a_q) : (a_q - b_q);
        prod   = RW'(a_q) * RW'(b_q);
    end

`ifdef ALU_SEQ_ACC_EN
    always_comb begin
        mac_sum = {1'b0, acc_q} + {1'b0, prod};
    end
`endif

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        neg_d   = 1'b0;
        err_d   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_d   = RW'(sum);
                carry_d = sum[WIDTH];
            end
            OP_SUB: begin
                res_d = RW'(mag);
                neg_d = a_lt_b;
            end
            OP_MUL: begin
                res_d = prod;
            end
            default: begin
`ifdef ALU_SEQ_ACC_EN
                res_d   = mac_sum[RW-1:0];
                carry_d = mac_sum[RW];
`else
                err_d   = 1'b1;
`endif
            end
        endcase
    end

    // Result and flags only move on a capture edge; they survive the out handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (capture) begin
            res_q   <= res_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            zero_q  <= (res_d == '0);
            err_q   <= err_d;
        end
    end

`ifdef ALU_SEQ_ACC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (capture && op_q == OP_MAC) begin
            acc_q <= mac_sum[RW-1:0];
        end
    end
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign busy          = busy_c;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vector table, reset/backpressure corners, random ops vs model.
// Latency: checks accept-to-out_valid cycle counts against the model.
// Backpressure: holds out_ready low for varying cycles and checks result/in_ready stability.
module tb_alu_op_sequencer;
    localparam int WIDTH   = 8;
    localparam int MUL_LAT = 4;

    logic clk;
    logic rst_n;
    logic busy;

    alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_op_sequencer #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

`ifdef ALU_SEQ_ACC_EN
    int model_acc = 0;
`endif

    typedef struct {
        logic [1:0] op;
        int         a;
        int         b;
        int         res;
        bit         c;
        bit         n;
        bit         z;
        bit         e;
        int         lat;
        int         hold;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] o, input int x, input int y, input int r,
                           input bit c, input bit n, input bit z, input bit e,
                           input int lat, input int hold);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r;
        v.c = c; v.n = n; v.z = z; v.e = e; v.lat = lat; v.hold = hold;
        vecs.push_back(v);
    endtask

    // Reference behaviour straight from the arithmetic rules.
    function automatic void model(input logic [1:0] o, input int x, input int y,
                                  output int r, output bit c, output bit n,
                                  output bit e, output int lat);
        r = 0; c = 0; n = 0; e = 0; lat = 1;
        case (o)
            2'd0: begin r = x + y; c = (r > 255); end
            2'd1: begin
                if (x < y) begin r = y - x; n = 1; end
                else r = x - y;
            end
            2'd2: begin r = x * y; lat = MUL_LAT; end
            default: begin
`ifdef ALU_SEQ_ACC_EN
                r = model_acc + x * y;
                c = (r > 65535);
                r = r % 65536;
                model_acc = r;
                lat = MUL_LAT;
`else
                e = 1;
`endif
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input int x, input int y,
                          input int er, input bit ec, input bit en, input bit ez, input bit ee,
                          input int el, input int hold);
        int  k;
        bit  seen;
        chk({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.op = o; bus.a = 8'(x); bus.b = 8'(y); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 2'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
        chk({tag, "/busy_exec"}, 32'(busy), 32'd1);
        chk({tag, "/in_ready_exec"}, 32'(bus.in_ready), 32'd0);
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (bus.out_valid) seen = 1;
            else begin
                bus.in_valid = 1'($urandom);
                bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 2'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        if (!seen) begin
            chk({tag, "/out_valid_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "/latency"}, 32'(k), 32'(el));
        chk({tag, "/result"}, 32'(bus.result), 32'(er));
        chk({tag, "/flags_cnze"}, {28'd0, bus.carry, bus.negative, bus.zero, bus.err},
            {28'd0, ec, en, ez, ee});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "/hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "/hold_result"}, 32'(bus.result), 32'(er));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "/out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "/in_ready_back"}, {31'd0, bus.in_ready}, {31'd0, ~busy});
        chk({tag, "/result_kept"}, 32'(bus.result), 32'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, lat, x, y;
        bit c, n, e;
        logic [1:0] o;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 2'b00; bus.a = '0; bus.b = '0;

        // Directed vectors (expected values computed by hand).
        add_vec(2'd0, 200, 100, 'h012C, 1, 0, 0, 0, 1, 0);
        add_vec(2'd0,   0,   0, 'h0000, 0, 0, 1, 0, 1, 1);
        add_vec(2'd1,   5,   9, 'h0004, 0, 1, 0, 0, 1, 0);
        add_vec(2'd1,   7,   7, 'h0000, 0, 0, 1, 0, 1, 2);
        add_vec(2'd1,   9,   5, 'h0004, 0, 0, 0, 0, 1, 0);
        add_vec(2'd2, 255, 255, 'hFE01, 0, 0, 0, 0, MUL_LAT, 3);
        add_vec(2'd0, 255,   1, 'h0100, 1, 0, 0, 0, 1, 0);
        add_vec(2'd2,   0,  77, 'h0000, 0, 0, 1, 0, MUL_LAT, 1);
`ifdef ALU_SEQ_ACC_EN
        add_vec(2'd3,   3,   4, 'h000C, 0, 0, 0, 0, MUL_LAT, 0);
        add_vec(2'd3,  10,  10, 'h0070, 0, 0, 0, 0, MUL_LAT, 0);
        add_vec(2'd3, 255, 255, 'hFE71, 0, 0, 0, 0, MUL_LAT, 0);
        add_vec(2'd3, 199,   2, 'hFFFF, 0, 0, 0, 0, MUL_LAT, 1);
        add_vec(2'd3,   1,   1, 'h0000, 1, 0, 1, 0, MUL_LAT, 0);
`else
        add_vec(2'd3,  12,  34, 'h0000, 0, 0, 1, 1, 1, 2);
`endif
        add_vec(2'd0,  17,   4, 'h0015, 0, 0, 0, 0, 1, 0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rel_result", 32'(bus.result), 32'd0);
        chk("rel_flags", {28'd0, bus.carry, bus.negative, bus.zero, bus.err}, 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].c, vecs[i].n, vecs[i].z, vecs[i].e, vecs[i].lat, vecs[i].hold);
        end

        // Reset in the middle of a multiply: the op must vanish.
        begin
            bit seen;
            bus.op = 2'd2; bus.a = 8'd255; bus.b = 8'd255; bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_result", 32'(bus.result), 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            seen = 0;
            repeat (MUL_LAT + 4) begin
                @(posedge clk); #1;
                if (bus.out_valid) seen = 1;
            end
            chk("midrst_no_result", 32'(seen), 32'd0);
            chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        end
`ifdef ALU_SEQ_ACC_EN
        model_acc = 0;
`endif

        // Random ops against the model.
        for (int t = 0; t < 60; t++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            if ($urandom_range(0, 4) == 0) x = 255;
            if ($urandom_range(0, 4) == 0) y = x;
            model(o, x, y, r, c, n, e, lat);
            run_op($sformatf("rnd%0d", t), o, x, y, r, c, n, (r == 0), e, lat,
                   $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
